// File: rtl/block_main_memory_if.sv
// rtl/block_main_memory_if.sv - request/response bundle between the cache and block main memory
interface block_main_memory_if #(
    parameter int ADDR_W      = 15,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4
);
    localparam int BLK_W = WORD_W * BLOCK_WORDS;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [BLK_W-1:0]  wr_block;
    logic              rsp_valid;
    logic [BLK_W-1:0]  rd_block;
    logic [WORD_W-1:0] word_out;
    logic              init_done;

    modport master (
        output req_valid, req_write, req_addr, wr_block,
        input  req_ready, rsp_valid, rd_block, word_out, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, wr_block,
        output req_ready, rsp_valid, rd_block, word_out, init_done
    );
endinterface

// File: rtl/block_main_memory.sv
// rtl/block_main_memory.sv - block-transfer main memory with self-init and programmable latency
module block_main_memory #(
    parameter int               ADDR_W      = 15,
    parameter int               WORD_W      = 32,
    parameter int               BLOCK_WORDS = 4,
    parameter int               LATENCY     = 2,
    parameter logic [WORD_W-1:0] INIT_VALUE = WORD_W'(1)
) (
    input  logic                clk,
    input  logic                rst,
    block_main_memory_if.slave  bus
);
    localparam int OFF_W  = $clog2(BLOCK_WORDS);
    localparam int BLK_W  = WORD_W * BLOCK_WORDS;
    localparam int NBLK_W = ADDR_W - OFF_W;
    localparam int NBLK   = 1 << NBLK_W;
    localparam int CNT_W  = $clog2(LATENCY + 1);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state;
    logic [NBLK_W-1:0] init_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [BLK_W-1:0]  lat_data;

    logic [BLK_W-1:0]  mem [NBLK];

    logic [NBLK_W-1:0] lat_blk;
    logic [OFF_W-1:0]  lat_off;
    logic [BLK_W-1:0]  rd_data;
    logic              access;

    assign lat_blk = lat_addr[ADDR_W-1:OFF_W];
    assign lat_off = lat_addr[OFF_W-1:0];
    assign rd_data = mem[lat_blk];
    assign access  = (state == S_BUSY) && (cnt == CNT_W'(LATENCY));

    // Storage carries no reset; the !rst gate keeps an aborted write from landing.
    always_ff @(posedge clk) begin
        if (!rst && state == S_INIT) begin
            mem[init_ptr] <= {BLOCK_WORDS{INIT_VALUE}};
        end else if (!rst && access && lat_write) begin
            mem[lat_blk] <= lat_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_INIT;
            init_ptr      <= '0;
            cnt           <= '0;
            lat_write     <= 1'b0;
            lat_addr      <= '0;
            lat_data      <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rd_block  <= '0;
            bus.word_out  <= '0;
            bus.init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == '1) begin
                        state         <= S_IDLE;
                        bus.init_done <= 1'b1;
                        bus.req_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        lat_write     <= bus.req_write;
                        lat_addr      <= bus.req_addr;
                        lat_data      <= bus.wr_block;
                        cnt           <= CNT_W'(1);
                        bus.req_ready <= 1'b0;
                        state         <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (access) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= S_RESP;
                        if (!lat_write) begin
                            bus.rd_block <= rd_data;
                            bus.word_out <= rd_data[lat_off*WORD_W +: WORD_W];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_block_main_memory.sv
// tb/tb_block_main_memory.sv - scoreboard bench for block_main_memory
module tb_block_main_memory;
    localparam int ADDR_W = 15;
    localparam int WORD_W = 32;
    localparam int BW     = 4;
    localparam int LAT    = 2;
    localparam int BLK_W  = WORD_W * BW;
    localparam int NBLK   = (1 << ADDR_W) / BW;
    localparam logic [WORD_W-1:0] INIT_V = 32'd1;

    typedef struct {
        logic [BLK_W-1:0]  rd;
        logic [WORD_W-1:0] wo;
        longint            t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    block_main_memory_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_WORDS(BW)) bus ();

    block_main_memory #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_WORDS(BW),
        .LATENCY(LAT), .INIT_VALUE(INIT_V)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [BLK_W-1:0]  ref_mem [NBLK];
    logic [BLK_W-1:0]  last_rd;
    logic [WORD_W-1:0] last_wo;
    longint            last_acc = -100;
    logic [12:0]       pool [4];
    logic [ADDR_W-1:0] ra;
    logic [BLK_W-1:0]  rdat;

    task automatic check(input string name, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < NBLK; i++) ref_mem[i] = {BW{INIT_V}};
        last_rd = '0;
        last_wo = '0;
    endtask

    // Caller must enter just after a rising edge so the request is set up cleanly.
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [BLK_W-1:0] d);
        int   n;
        int   blk;
        int   off;
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.wr_block  = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", BLK_W'(n), BLK_W'(0));
                bus.req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        blk = int'(a) / BW;
        off = int'(a) % BW;
        if (w) begin
            ref_mem[blk] = d;
        end else begin
            last_rd = ref_mem[blk];
            last_wo = last_rd[off*WORD_W +: WORD_W];
        end
        e.rd = last_rd;
        e.wo = last_wo;
        e.t  = longint'($time) + LAT * 10 + 5;
        sb.push_back(e);
        last_acc = longint'($time);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!bus.req_ready && n < 9000) begin
            n++;
            @(negedge clk);
        end
        check("init_cycles", BLK_W'(n), BLK_W'(8192));
        check("init_done", BLK_W'(bus.init_done), BLK_W'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", BLK_W'(sb.size()), BLK_W'(0));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (longint'($time) == last_acc + 5)
                check("ready_low_after_accept", BLK_W'(bus.req_ready), BLK_W'(0));
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp got rsp_valid=1 want no response at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_time", BLK_W'($time), BLK_W'(mon_e.t));
                    check("rd_block", bus.rd_block, mon_e.rd);
                    check("word_out", BLK_W'(bus.word_out), BLK_W'(mon_e.wo));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.wr_block  = '0;
        pool[0] = 13'd0;
        pool[1] = 13'd1;
        pool[2] = 13'd8191;
        pool[3] = 13'd37;
        model_init();

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", BLK_W'(bus.req_ready), BLK_W'(0));
        check("rst_rsp_valid", BLK_W'(bus.rsp_valid), BLK_W'(0));
        check("rst_rd_block", bus.rd_block, BLK_W'(0));
        check("rst_word_out", BLK_W'(bus.word_out), BLK_W'(0));
        check("rst_init_done", BLK_W'(bus.init_done), BLK_W'(0));

        @(negedge clk);
        rst = 1'b0;
        wait_init();

        issue(1'b0, 15'h7FFF, '0);
        issue(1'b0, 15'h0006, '0);
        issue(1'b1, 15'h0010, {32'hD, 32'hC, 32'hB, 32'hA});
        issue(1'b0, 15'h0013, '0);
        drain();
        check("word_out_0x13", BLK_W'(bus.word_out), BLK_W'(32'hD));

        // Back-to-back calls keep req_valid high with a new address through BUSY/RESP.
        issue(1'b0, 15'h0100, '0);
        issue(1'b1, 15'h0104, {$urandom, $urandom, $urandom, $urandom});
        issue(1'b0, 15'h0105, '0);
        drain();

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) ra = {pool[$urandom_range(0, 3)], 2'($urandom)};
            else                           ra = ADDR_W'($urandom);
            rdat = {$urandom, $urandom, $urandom, $urandom};
            issue(1'($urandom_range(0, 1)), ra, rdat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        issue(1'b1, 15'h0020, {$urandom, $urandom, $urandom, $urandom});
        #3 rst = 1'b1;
        #1;
        check("abort_req_ready", BLK_W'(bus.req_ready), BLK_W'(0));
        check("abort_rsp_valid", BLK_W'(bus.rsp_valid), BLK_W'(0));
        check("abort_rd_block", bus.rd_block, BLK_W'(0));
        check("abort_word_out", BLK_W'(bus.word_out), BLK_W'(0));
        check("abort_init_done", BLK_W'(bus.init_done), BLK_W'(0));
        sb.delete();
        model_init();
        last_acc = -100;

        @(negedge clk);
        rst = 1'b0;
        wait_init();
        issue(1'b0, 15'h0020, '0);
        issue(1'b0, 15'h0023, '0);
        drain();
        check("reinit_0x20", bus.rd_block, {BW{INIT_V}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
